// File: rtl/cpu_defs.sv
// Shared CPU datapath definitions: instruction/PC widths, the NOP encoding and the packed
// IF/ID tuple. Used by if_id_queue (optional IF_ID_QUEUE_BYPASS_EN build).
package cpu_defs;

    localparam int unsigned INSTR_W = 16;
    localparam int unsigned PC_W    = 16;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0800;

    // Field offsets within the 48-bit tuple: {instr, pc, pc_plus_two}
    localparam int unsigned TUPLE_W   = INSTR_W + 2 * PC_W;
    localparam int unsigned PC2_LSB   = 0;
    localparam int unsigned PC_LSB    = PC_W;
    localparam int unsigned INSTR_LSB = 2 * PC_W;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
        logic [PC_W-1:0]    pc_plus_two;
    } if_id_tuple_t;

    function automatic if_id_tuple_t make_tuple(input logic [INSTR_W-1:0] instr,
                                                input logic [PC_W-1:0]    pc,
                                                input logic [PC_W-1:0]    pc_plus_two);
        if_id_tuple_t t;
        t.instr       = instr;
        t.pc          = pc;
        t.pc_plus_two = pc_plus_two;
        return t;
    endfunction

endpackage

// File: rtl/if_id_queue_storage.sv
// Register array backing the IF/ID queue: one synchronous write port, asynchronous read.
// Data is not reset; validity is tracked by the pointers in if_id_queue.
module if_id_queue_storage
    import cpu_defs::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned PTR_W = 1
) (
    input  logic               clk_i,
    input  logic               wr_en_i,
    input  logic [PTR_W-1:0]   wr_ptr_i,
    input  if_id_tuple_t       wr_data_i,
    input  logic [PTR_W-1:0]   rd_ptr_i,
    output if_id_tuple_t       rd_data_o
);

    if_id_tuple_t mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_ptr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_ptr_i];

endmodule

// File: rtl/if_id_queue.sv
// IF/ID instruction queue: circular buffer of {instr, pc, pc+2} with flush and NOP on empty.
// Defining IF_ID_QUEUE_BYPASS_EN adds a zero-latency path from in_* to out_* when empty.
module if_id_queue #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned PTR_W = 1,
    parameter logic [cpu_defs::INSTR_W-1:0] NOP_INSTR = cpu_defs::NOP_INSTR
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic [cpu_defs::INSTR_W-1:0] in_instr,
    input  logic [cpu_defs::PC_W-1:0]    in_pc,
    input  logic [cpu_defs::PC_W-1:0]    in_pc_plus_two,
    output logic                         in_ready,
    input  logic                         flush,
    output logic                         out_valid,
    output logic [cpu_defs::INSTR_W-1:0] out_instr,
    output logic [cpu_defs::PC_W-1:0]    out_pc,
    output logic [cpu_defs::PC_W-1:0]    out_pc_plus_two,
    input  logic                         out_ready,
    output logic [PTR_W:0]               count
);
    import cpu_defs::*;

    localparam logic [PTR_W:0] Full = (PTR_W + 1)'(DEPTH);

    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;
    if_id_tuple_t     wr_tuple, rd_tuple, out_tuple;
    logic             enq, deq, byp, occupied;

    assign wr_tuple = make_tuple(in_instr, in_pc, in_pc_plus_two);

    if_id_queue_storage #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_storage (
        .clk_i     (clk),
        .wr_en_i   (enq),
        .wr_ptr_i  (tail_q),
        .wr_data_i (wr_tuple),
        .rd_ptr_i  (head_q),
        .rd_data_o (rd_tuple)
    );

    always_comb begin
        occupied = (count_q != '0);
        in_ready = (count_q != Full);
`ifdef IF_ID_QUEUE_BYPASS_EN
        byp = !occupied && in_valid && !flush;
`else
        byp = 1'b0;
`endif
        out_valid = (occupied && !flush) || byp;
        // A bypassed tuple that decode takes this cycle never lands in storage
        enq = in_valid && in_ready && !flush && !(byp && out_ready);
        deq = occupied && !flush && out_ready;

        if (byp) begin
            out_tuple = wr_tuple;
        end else if (occupied && !flush) begin
            out_tuple = rd_tuple;
        end else begin
            out_tuple = make_tuple(NOP_INSTR, '0, '0);
        end

        head_d  = head_q + PTR_W'(deq);
        tail_d  = tail_q + PTR_W'(enq);
        count_d = count_q + (PTR_W + 1)'(enq) - (PTR_W + 1)'(deq);
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign out_instr       = out_tuple.instr;
    assign out_pc          = out_tuple.pc;
    assign out_pc_plus_two = out_tuple.pc_plus_two;
    assign count           = count_q;

    a_count_bound: assert property (@(posedge clk) disable iff (rst) count_q <= Full)
        else $error("if_id_queue occupancy out of range");

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue: vector table for fill/drain plus scoreboarded sequences.
// Expectations follow IF_ID_QUEUE_BYPASS_EN when it is defined for the build.
module tb_if_id_queue;
    import cpu_defs::*;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned PTR_W = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, flush, out_valid, out_ready;
    logic [15:0] in_instr, in_pc, in_pc_plus_two;
    logic [15:0] out_instr, out_pc, out_pc_plus_two;
    logic [PTR_W:0] count;

    int n_checks = 0;
    int n_fail   = 0;

    if_id_tuple_t sb_q[$];

    if_id_queue #(
        .DEPTH     (DEPTH),
        .PTR_W     (PTR_W),
        .NOP_INSTR (16'h0800)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_instr        (in_instr),
        .in_pc           (in_pc),
        .in_pc_plus_two  (in_pc_plus_two),
        .in_ready        (in_ready),
        .flush           (flush),
        .out_valid       (out_valid),
        .out_instr       (out_instr),
        .out_pc          (out_pc),
        .out_pc_plus_two (out_pc_plus_two),
        .out_ready       (out_ready),
        .count           (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [15:0] instr, input logic [15:0] pc,
                         input logic ordy, input logic fl);
        in_valid       = iv;
        in_instr       = instr;
        in_pc          = pc;
        in_pc_plus_two = pc + 16'd2;
        out_ready      = ordy;
        flush          = fl;
    endtask

    // Called mid-cycle: compare outputs against the scoreboard, update it, advance one clock
    task automatic sb_cycle(input string tag);
        logic         byp, ev, enq, deq;
        if_id_tuple_t exp;
        byp = 1'b0;
`ifdef IF_ID_QUEUE_BYPASS_EN
        byp = (sb_q.size() == 0) && in_valid && !flush;
`endif
        ev = ((sb_q.size() != 0) && !flush) || byp;
        if (byp)    exp = make_tuple(in_instr, in_pc, in_pc_plus_two);
        else if (ev) exp = sb_q[0];
        else        exp = make_tuple(16'h0800, 16'h0, 16'h0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'(ev));
        check({tag, "_out_instr"}, 32'(out_instr), 32'(exp.instr));
        check({tag, "_out_pc"}, 32'(out_pc), 32'(exp.pc));
        check({tag, "_out_pc2"}, 32'(out_pc_plus_two), 32'(exp.pc_plus_two));
        check({tag, "_count"}, 32'(count), 32'(sb_q.size()));
        check({tag, "_in_ready"}, 32'(in_ready), 32'(sb_q.size() != DEPTH));
        enq = in_valid && (sb_q.size() < DEPTH) && !flush && !(byp && out_ready);
        deq = ev && out_ready && !byp;
        if (flush) begin
            sb_q.delete();
        end else begin
            if (deq) void'(sb_q.pop_front());
            if (enq) sb_q.push_back(make_tuple(in_instr, in_pc, in_pc_plus_two));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input string tag, input logic iv, input logic [15:0] instr,
                       input logic [15:0] pc, input logic ordy, input logic fl);
        drive(iv, instr, pc, ordy, fl);
        #4;
        sb_cycle(tag);
    endtask

    typedef struct {
        logic        iv;
        logic [15:0] instr;
        logic [15:0] pc;
        logic        ordy;
        logic        ev;
        logic [15:0] einstr;
        logic [15:0] epc;
        logic [1:0]  ecount;
        logic        erdy;
    } vec_t;

    vec_t vt[6];

    initial begin
        // Fill/drain vectors: expected outputs sampled mid-cycle with the row's inputs applied
`ifdef IF_ID_QUEUE_BYPASS_EN
        vt[0] = '{1'b1, 16'h1111, 16'd0, 1'b0, 1'b1, 16'h1111, 16'd0, 2'd0, 1'b1};
`else
        vt[0] = '{1'b1, 16'h1111, 16'd0, 1'b0, 1'b0, 16'h0800, 16'd0, 2'd0, 1'b1};
`endif
        vt[1] = '{1'b1, 16'h2222, 16'd2, 1'b0, 1'b1, 16'h1111, 16'd0, 2'd1, 1'b1};
        vt[2] = '{1'b1, 16'h4444, 16'd4, 1'b0, 1'b1, 16'h1111, 16'd0, 2'd2, 1'b0};
        vt[3] = '{1'b0, 16'h0000, 16'd0, 1'b1, 1'b1, 16'h1111, 16'd0, 2'd2, 1'b0};
        vt[4] = '{1'b0, 16'h0000, 16'd0, 1'b1, 1'b1, 16'h2222, 16'd2, 2'd1, 1'b1};
        vt[5] = '{1'b0, 16'h0000, 16'd0, 1'b1, 1'b0, 16'h0800, 16'd0, 2'd0, 1'b1};

        rst = 1'b1;
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_instr", 32'(out_instr), 32'h0800);
        check("rst_count", 32'(count), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset mid-run with a full queue: outputs clear without a clock edge
        cyc("t1_push0", 1'b1, 16'hA0A0, 16'd0, 1'b0, 1'b0);
        cyc("t1_push1", 1'b1, 16'hA1A1, 16'd2, 1'b0, 1'b0);
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        #1;
        check("t1_pre_count", 32'(count), 32'd2);
        #1;
        rst = 1'b1;
        #1;
        check("t1_async_out_valid", 32'(out_valid), 32'd0);
        check("t1_async_out_instr", 32'(out_instr), 32'h0800);
        check("t1_async_out_pc", 32'(out_pc), 32'd0);
        check("t1_async_count", 32'(count), 32'd0);
        check("t1_async_in_ready", 32'(in_ready), 32'd1);
        sb_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Fill/drain from the vector table
        for (int i = 0; i < 6; i++) begin
            drive(vt[i].iv, vt[i].instr, vt[i].pc, vt[i].ordy, 1'b0);
            #4;
            check($sformatf("t2_out_valid[%0d]", i), 32'(out_valid), 32'(vt[i].ev));
            check($sformatf("t2_out_instr[%0d]", i), 32'(out_instr), 32'(vt[i].einstr));
            check($sformatf("t2_out_pc[%0d]", i), 32'(out_pc), 32'(vt[i].epc));
            check($sformatf("t2_count[%0d]", i), 32'(count), 32'(vt[i].ecount));
            check($sformatf("t2_in_ready[%0d]", i), 32'(in_ready), 32'(vt[i].erdy));
            sb_cycle($sformatf("t2_sb[%0d]", i));
        end

        // Steady stream: one in, one out per cycle
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 16'(2 * i), 16'(2 * i), 1'b1, 1'b0);
            #4;
`ifdef IF_ID_QUEUE_BYPASS_EN
            check($sformatf("t3_count[%0d]", i), 32'(count), 32'd0);
            check($sformatf("t3_instr[%0d]", i), 32'(out_instr), 32'(2 * i));
`else
            if (i > 0) begin
                check($sformatf("t3_count[%0d]", i), 32'(count), 32'd1);
                check($sformatf("t3_lag[%0d]", i), 32'(out_instr), 32'(2 * (i - 1)));
            end
`endif
            sb_cycle($sformatf("t3_sb[%0d]", i));
        end
        cyc("t3_drain", 1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        cyc("t3_idle", 1'b0, 16'h0, 16'h0, 1'b1, 1'b0);

        // Flush with a full queue and a same-cycle fetch
        cyc("t4_push0", 1'b1, 16'hB0B0, 16'd10, 1'b0, 1'b0);
        cyc("t4_push1", 1'b1, 16'hB1B1, 16'd12, 1'b0, 1'b0);
        drive(1'b1, 16'h3333, 16'd20, 1'b0, 1'b1);
        #4;
        check("t4_flush_out_valid", 32'(out_valid), 32'd0);
        check("t4_flush_out_instr", 32'(out_instr), 32'h0800);
        sb_cycle("t4_flush");
        drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        #4;
        check("t4_after_count", 32'(count), 32'd0);
        check("t4_after_out_valid", 32'(out_valid), 32'd0);
        sb_cycle("t4_after");
        cyc("t4_flush_empty", 1'b0, 16'h0, 16'h0, 1'b1, 1'b1);

        // Pointer wrap: continuous pushes with out_ready toggling
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 16'hC000 + 16'(i), 16'(4 * i), logic'(i % 2), 1'b0);
            #4;
            check($sformatf("t5_bound[%0d]", i), 32'(count <= DEPTH), 32'd1);
            sb_cycle($sformatf("t5_sb[%0d]", i));
        end
        for (int i = 0; i < 3; i++) begin
            cyc($sformatf("t5_drain[%0d]", i), 1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        end

        // Empty queue, fetch and decode both ready
        drive(1'b1, 16'hABCD, 16'd40, 1'b1, 1'b0);
        #4;
`ifdef IF_ID_QUEUE_BYPASS_EN
        check("t6_same_instr", 32'(out_instr), 32'hABCD);
        check("t6_same_valid", 32'(out_valid), 32'd1);
`else
        check("t6_same_valid", 32'(out_valid), 32'd0);
`endif
        sb_cycle("t6_c0");
        drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        #4;
`ifdef IF_ID_QUEUE_BYPASS_EN
        check("t6_next_count", 32'(count), 32'd0);
`else
        check("t6_next_count", 32'(count), 32'd1);
        check("t6_next_instr", 32'(out_instr), 32'hABCD);
`endif
        sb_cycle("t6_c1");
        drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        #4;
        check("t6_final_count", 32'(count), 32'd0);
        sb_cycle("t6_c2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
